// File: rtl/mlp_sequencer.sv
// Layer sequencer for a three-layer MLP: starts fc1/fc2/fc3 in turn, guards each
// layer with a timeout, then scans the final-layer BRAM for the signed argmax.
module mlp_sequencer #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned NUM_CLASSES    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [2:0]                     layer_start,
    input  logic [2:0]                     layer_done,
    output logic [1:0]                     cur_layer,
    output logic                           out_rd_en,
    output logic [$clog2(NUM_CLASSES)-1:0] out_rd_addr,
    input  logic [DATA_WIDTH-1:0]          out_rd_data,
    output logic [$clog2(NUM_CLASSES)-1:0] output_class,
    output logic [DATA_WIDTH-1:0]          max_val
);

    localparam int unsigned AW = $clog2(NUM_CLASSES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CLASSES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LSTART,
        LWAIT,
        ARGRD,
        FIN,
        ERR
    } state_t;

    state_t                state, state_n;
    logic [1:0]            layer_idx, layer_idx_n;
    logic [TW-1:0]         tmo_cnt, tmo_cnt_n;
    logic                  rd_vld, rd_vld_n;
    logic [AW-1:0]         rd_idx, rd_idx_n;
    logic [DATA_WIDTH-1:0] run_max, run_max_n;
    logic [AW-1:0]         run_idx, run_idx_n;

    logic                  busy_n, done_n, error_n, rd_en_n;
    logic [2:0]            layer_start_n;
    logic [1:0]            cur_layer_n;
    logic [AW-1:0]         rd_addr_n, class_n;
    logic [DATA_WIDTH-1:0] max_n;
    logic                  layer_done_sel_c;

    // Only the active layer's completion bit is ever looked at.
    assign layer_done_sel_c = |(layer_done & (3'b001 << layer_idx));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            layer_idx    <= '0;
            tmo_cnt      <= '0;
            rd_vld       <= 1'b0;
            rd_idx       <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            layer_start  <= '0;
            cur_layer    <= '0;
            out_rd_en    <= 1'b0;
            out_rd_addr  <= '0;
            output_class <= '0;
            max_val      <= '0;
        end else begin
            state        <= state_n;
            layer_idx    <= layer_idx_n;
            tmo_cnt      <= tmo_cnt_n;
            rd_vld       <= rd_vld_n;
            rd_idx       <= rd_idx_n;
            run_max      <= run_max_n;
            run_idx      <= run_idx_n;
            busy         <= busy_n;
            done         <= done_n;
            error        <= error_n;
            layer_start  <= layer_start_n;
            cur_layer    <= cur_layer_n;
            out_rd_en    <= rd_en_n;
            out_rd_addr  <= rd_addr_n;
            output_class <= class_n;
            max_val      <= max_n;
        end
    end

    // Outputs are derived from the next state so they line up with the state they describe.
    always_comb begin
        state_n       = state;
        layer_idx_n   = layer_idx;
        tmo_cnt_n     = tmo_cnt;
        run_max_n     = run_max;
        run_idx_n     = run_idx;
        rd_vld_n      = out_rd_en;
        rd_idx_n      = out_rd_addr;
        rd_en_n       = 1'b0;
        rd_addr_n     = out_rd_addr;
        class_n       = output_class;
        max_n         = max_val;
        busy_n        = 1'b0;
        done_n        = 1'b0;
        error_n       = 1'b0;
        layer_start_n = '0;
        cur_layer_n   = '0;

        case (state)
            IDLE, ERR: begin
                if (start) begin
                    state_n     = LSTART;
                    layer_idx_n = 2'd0;
                end
            end
            LSTART: begin
                tmo_cnt_n = '0;
                state_n   = LWAIT;
            end
            LWAIT: begin
                if (layer_done_sel_c) begin
                    if (layer_idx == 2'd2) begin
                        state_n   = ARGRD;
                        rd_en_n   = 1'b1;
                        rd_addr_n = '0;
                    end else begin
                        state_n     = LSTART;
                        layer_idx_n = layer_idx + 2'd1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = ERR;
                end else begin
                    tmo_cnt_n = tmo_cnt + TW'(1);
                end
            end
            ARGRD: begin
                if (out_rd_en && (out_rd_addr != LAST_IDX)) begin
                    rd_en_n   = 1'b1;
                    rd_addr_n = out_rd_addr + AW'(1);
                end
                // Data trails the read strobe by one cycle; strict '>' keeps the lowest index on ties.
                if (rd_vld) begin
                    if ((rd_idx == '0) || ($signed(out_rd_data) > $signed(run_max))) begin
                        run_max_n = out_rd_data;
                        run_idx_n = rd_idx;
                    end
                    if (rd_idx == LAST_IDX) begin
                        state_n = FIN;
                        class_n = run_idx_n;
                        max_n   = run_max_n;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n  = (state_n == LSTART) || (state_n == LWAIT) || (state_n == ARGRD);
        done_n  = (state_n == FIN);
        error_n = (state_n == ERR);
        if (state_n == LSTART) begin
            layer_start_n = 3'b001 << layer_idx_n;
        end
        case (state_n)
            LSTART, LWAIT: cur_layer_n = layer_idx_n;
            ARGRD, FIN:    cur_layer_n = 2'd2;
            default:       cur_layer_n = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer: layer handshakes, argmax scan, timeout, strays,
// reset abort and back-to-back starts, all against hand-computed expectations.
module tb_mlp_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 10;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    layer_start;
    logic [2:0]    layer_done;
    logic [1:0]    cur_layer;
    logic          out_rd_en;
    logic [3:0]    out_rd_addr;
    logic [DW-1:0] out_rd_data = '0;
    logic [3:0]    output_class;
    logic [DW-1:0] max_val;

    logic [DW-1:0] mem [NC];
    int n_checks = 0;
    int n_errors = 0;

    mlp_sequencer #(
        .DATA_WIDTH    (DW),
        .NUM_CLASSES   (NC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .cur_layer   (cur_layer),
        .out_rd_en   (out_rd_en),
        .out_rd_addr (out_rd_addr),
        .out_rd_data (out_rd_data),
        .output_class(output_class),
        .max_val     (max_val)
    );

    always #5 clk = ~clk;

    // Final-layer BRAM: one-cycle read latency.
    always @(posedge clk) begin
        if (out_rd_en) out_rd_data <= mem[out_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start an inference and walk fc1..fc3; returns in the first ARGRD cycle.
    task automatic run_layers(input int d0, input int d1, input int d2,
                              input bit stray, input bit hold);
        int dly[3];
        dly = '{d0, d1, d2};
        start = 1'b1;
        tick;
        if (!hold) start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("error_cleared", 32'(error), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("layer_start", 32'(layer_start), 32'd1 << i);
            check("cur_layer_lstart", 32'(cur_layer), 32'(i));
            for (int c = 0; c < dly[i]; c++) begin
                if (stray && i == 0 && c == 0) layer_done = 3'b001;
                if (stray && i == 0 && c == 2) begin
                    layer_done = 3'b110;
                    start      = 1'b1;
                end
                tick;
                layer_done = 3'b000;
                if (!hold) start = 1'b0;
                check("no_layer_start", 32'(layer_start), 32'd0);
                check("cur_layer_wait", 32'(cur_layer), 32'(i));
                check("busy_wait", 32'(busy), 32'd1);
            end
            layer_done = 3'b001 << i;
            tick;
            layer_done = 3'b000;
        end
    endtask

    // Scan phase through the done pulse and one idle cycle.
    task automatic run_argmax(input logic [DW-1:0] exp_max, input int exp_cls);
        for (int j = 0; j < int'(NC); j++) begin
            check("rd_en", 32'(out_rd_en), 32'd1);
            check("rd_addr", 32'(out_rd_addr), 32'(j));
            check("cur_layer_argrd", 32'(cur_layer), 32'd2);
            tick;
        end
        check("rd_en_off", 32'(out_rd_en), 32'd0);
        check("rd_addr_hold", 32'(out_rd_addr), 32'(NC - 1));
        check("no_early_done", 32'(done), 32'd0);
        tick;
        check("done", 32'(done), 32'd1);
        check("busy_fin", 32'(busy), 32'd0);
        check("class", 32'(output_class), 32'(exp_cls));
        check("max", 32'(max_val), 32'(exp_max));
        check("cur_layer_fin", 32'(cur_layer), 32'd2);
        tick;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_no_lstart", 32'(layer_start), 32'd0);
        check("class_hold", 32'(output_class), 32'(exp_cls));
        check("max_hold", 32'(max_val), 32'(exp_max));
        check("cur_layer_idle", 32'(cur_layer), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_lstart"}, 32'(layer_start), 32'd0);
        check({tag, "_cur_layer"}, 32'(cur_layer), 32'd0);
        check({tag, "_rd_en"}, 32'(out_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(out_rd_addr), 32'd0);
        check({tag, "_class"}, 32'(output_class), 32'd0);
        check({tag, "_max"}, 32'(max_val), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        layer_done = 3'b000;
        #1;
        check_all_zero("reset");
        tick;
        tick;
        rst = 1'b1;

        // Nominal: ties at index 2 and 5, 0x8000 is the most negative.
        mem = '{16'h0100, 16'hFF00, 16'h0280, 16'h0040, 16'h0000,
                16'h0280, 16'h0010, 16'h8000, 16'h0200, 16'h0001};
        run_layers(5, 7, 3, 1'b0, 1'b0);
        run_argmax(16'h0280, 2);

        // All negative, descending.
        mem = '{16'hFFF0, 16'hFF00, 16'hF000, 16'hE000, 16'hC000,
                16'hB000, 16'hA000, 16'h9000, 16'h8800, 16'h8000};
        run_layers(2, 2, 2, 1'b0, 1'b0);
        run_argmax(16'hFFF0, 0);

        // Maximum at the last index.
        mem = '{16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005,
                16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0006};
        run_layers(1, 1, 1, 1'b0, 1'b0);
        run_argmax(16'h0006, 9);

        // Timeout on fc2.
        start = 1'b1;
        tick;
        start = 1'b0;
        check("to_lstart0", 32'(layer_start), 32'd1);
        repeat (5) tick;
        layer_done = 3'b001;
        tick;
        layer_done = 3'b000;
        check("to_lstart1", 32'(layer_start), 32'd2);
        tick;
        for (int j = 0; j < int'(TO); j++) begin
            check("to_no_error_yet", 32'(error), 32'd0);
            check("to_busy", 32'(busy), 32'd1);
            tick;
        end
        check("to_error", 32'(error), 32'd1);
        check("to_busy_low", 32'(busy), 32'd0);
        check("to_no_done", 32'(done), 32'd0);
        check("to_cur_layer", 32'(cur_layer), 32'd0);
        check("to_class_kept", 32'(output_class), 32'd9);
        check("to_max_kept", 32'(max_val), 32'h0006);
        repeat (3) tick;
        check("to_error_sticky", 32'(error), 32'd1);
        check("to_no_done_later", 32'(done), 32'd0);
        run_layers(3, 3, 3, 1'b0, 1'b0);
        run_argmax(16'h0006, 9);

        // Stray layer_done bits and start while waiting on fc1.
        mem = '{16'h0100, 16'hFF00, 16'h0280, 16'h0040, 16'h0000,
                16'h0280, 16'h0010, 16'h8000, 16'h0200, 16'h0001};
        run_layers(5, 4, 2, 1'b1, 1'b0);
        run_argmax(16'h0280, 2);

        // Reset abort in the middle of the scan.
        run_layers(2, 2, 2, 1'b0, 1'b0);
        repeat (4) tick;
        check("abort_addr4", 32'(out_rd_addr), 32'd4);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        tick;
        tick;
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_no_lstart", 32'(layer_start), 32'd0);
        rst = 1'b1;
        run_layers(2, 2, 2, 1'b0, 1'b0);
        run_argmax(16'h0280, 2);

        // Start held high: one idle cycle between inferences.
        mem = '{16'hFFF0, 16'hFF00, 16'hF000, 16'hE000, 16'hC000,
                16'hB000, 16'hA000, 16'h9000, 16'h8800, 16'h8000};
        run_layers(1, 2, 1, 1'b0, 1'b1);
        run_argmax(16'hFFF0, 0);
        run_layers(2, 1, 1, 1'b0, 1'b1);
        run_argmax(16'hFFF0, 0);
        start = 1'b0;
        tick;
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_lstart", 32'(layer_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
